// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit:
//   - state_t      : FSM state encoding (also exported on state_debug)
//   - OP_*         : major opcodes decoded by the FSM
//   - ALU_*        : ALUControl encodings driven to the datapath ALU
//   - ALUOP_*      : internal ALU operation class fed to riscv_alu_decoder
//   - RES_*/SRCA_*/SRCB_*/IMM_* : datapath multiplexer select encodings
//   - imm_src_of() : immediate format selected from the opcode
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// -----------------------------------------------------------------------------
// riscv_alu_decoder
// Combinational ALU control decode.
//   ALUOp[1:0]    in  : operation class (add / sub / decode from funct fields)
//   funct3[2:0]   in  : IR[14:12]
//   funct7b5      in  : IR[30]
//   op5           in  : IR[5], distinguishes R-type (1) from I-type (0)
//   ALUControl    out : ALU operation
//   funct_illegal out : funct3 names an operation this ALU does not implement
// -----------------------------------------------------------------------------
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl,
  output logic       funct_illegal
);

  // funct_illegal depends on funct3 only, so the FSM can check it in DECODE
  // while the ALU itself is busy with the branch-target add.
  always_comb begin
    funct_illegal = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: funct_illegal = 1'b0;
      default:                        funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has no sub form: IR[30] is immediate data when op5=0
          3'b000:  ALUControl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
// Moore-style control FSM for a multicycle RV32I datapath, with memory-ready
// handshake, illegal-instruction trapping and a retired-instruction counter.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   op/funct3/funct7b5  : instruction register fields
//   zero                : ALU zero flag (branch resolution)
//   mem_ready           : memory completes the current access this cycle
//   PCWrite..ALUControl : datapath enables and mux selects (combinational)
//   illegal             : sticky illegal-instruction flag
//   instr_retired       : one-cycle pulse per completed instruction
//   retired_cnt         : retired instruction count, wraps modulo 2^CNT_W
//   state_debug         : current state encoding
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned SUPPORT_BNE     = 1,
  parameter int unsigned SUPPORT_JAL     = 1,
  parameter int unsigned TRAP_ON_ILLEGAL = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_debug
);

  state_t           state_reg, state_next;
  logic             illegal_reg;
  logic             instr_retired_reg;
  logic [CNT_W-1:0] retired_cnt_reg;

  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       decode_illegal;
  logic       retire_now;
  logic       branch_ok;

  riscv_alu_decoder u_alu_decoder (
    .ALUOp        (alu_op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .op5          (op[5]),
    .ALUControl   (ALUControl),
    .funct_illegal(funct_illegal)
  );

  // Branch flavours this build can execute.
  assign branch_ok = (funct3 == 3'b000) ||
                     ((SUPPORT_BNE != 0) && (funct3 == 3'b001));

  always_comb begin
    state_next     = state_reg;
    PCWrite        = 1'b0;
    AdrSrc         = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    ResultSrc      = RES_ALUOUT;
    ALUSrcA        = SRCA_PC;
    ALUSrcB        = SRCB_RS2;
    RegWrite       = 1'b0;
    alu_op         = ALUOP_ADD;
    decode_illegal = 1'b0;
    retire_now     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 goes straight back into PC through ResultSrc=ALUResult
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R: begin
            if (funct_illegal) decode_illegal = 1'b1;
            else               state_next     = S_EXECR;
          end
          OP_I: begin
            if (funct_illegal) decode_illegal = 1'b1;
            else               state_next     = S_EXECI;
          end
          OP_BRANCH: begin
            if (branch_ok) state_next     = S_BRANCH;
            else           decode_illegal = 1'b1;
          end
          OP_JAL: begin
            if (SUPPORT_JAL != 0) state_next     = S_JAL;
            else                  decode_illegal = 1'b1;
          end
          default: decode_illegal = 1'b1;
        endcase
        if (decode_illegal) state_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        retire_now = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire_now = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire_now = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        if (funct3 == 3'b000)                             PCWrite = zero;
        else if ((SUPPORT_BNE != 0) && (funct3 == 3'b001)) PCWrite = ~zero;
        retire_now = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target from DECODE) while the ALU forms OldPC+4 for rd
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_FETCH;
      illegal_reg       <= 1'b0;
      instr_retired_reg <= 1'b0;
      retired_cnt_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      illegal_reg       <= illegal_reg | decode_illegal;
      instr_retired_reg <= retire_now;
      if (retire_now) retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
    end
  end

  assign ImmSrc        = imm_src_of(op);
  assign illegal       = illegal_reg;
  assign instr_retired = instr_retired_reg;
  assign retired_cnt   = retired_cnt_reg;
  assign state_debug   = state_reg;

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multicycle RISC-V (RV32I subset) control unit: a Moore FSM plus ALU and immediate decoders.
- Drives the shared-datapath control lines that the single-cycle benches currently drive by hand.
- Adds a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath (PC/OldPC/IR/ALUOut/Data registers).

Parameters:
- SUPPORT_BNE, 1: 1 = funct3=001 branches on !zero; 0 = funct3=001 is illegal.
- SUPPORT_JAL, 1: 1 = opcode 1101111 decoded; 0 = illegal.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters S_TRAP (sticky); 0 = illegal returns to S_FETCH with no side effect.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR/OldPC enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- RegWrite  out  1  register-file write enable.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  sticky illegal-instruction flag.
- instr_retired  out  1  one-cycle pulse per completed instruction.
- retired_cnt  out  CNT_W  count of retired instructions.
- state_debug  out  4  current state encoding.

Behaviour:
- Reset is asynchronous and active-low on rst_n. While low: state=S_FETCH, illegal=0, retired_cnt=0, instr_retired=0.
- Only the state, illegal, retired_cnt and instr_retired are registered. All other outputs decode combinationally from state and IR fields. During and after reset they therefore show the S_FETCH values, with PCWrite=IRWrite=0 while mem_ready=0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11.
- Outputs are 0 unless listed below. ALUSrcA, ALUSrcB and ResultSrc default to 00.
- FETCH:
  - AdrSrc=0, ALUSrcB=10, ResultSrc=10, ALU add.
  - IRWrite=PCWrite=mem_ready.
  - Holds in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> illegal path
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Retires, then goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Retires on mem_ready, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU from the funct decode. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU from the funct decode. Goes to ALUWB.
- ALUWB: RegWrite=1. Retires, then goes to FETCH.
- BRANCH: ALUSrcA=10, ALU sub.
  - funct3=000: PCWrite=zero.
  - funct3=001 (only when SUPPORT_BNE=1): PCWrite=!zero.
  - Retires, then goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1. Goes to ALUWB (writes PC+4 to rd).
- ALU funct decode:
  - 000: sub if funct7b5 & op[5], else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3 in EXECR/EXECI is illegal; this is detected in DECODE.
- ImmSrc from op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- Illegal path (from DECODE):
  - Sets illegal=1.
  - TRAP_ON_ILLEGAL=1: goes to TRAP, which holds with all enables 0 until reset.
  - TRAP_ON_ILLEGAL=0: goes to FETCH; illegal stays sticky; no retire.
- Retire: instr_retired=1 for exactly one cycle on the transition out of MEMWB, MEMWRITE (mem_ready), ALUWB or BRANCH. retired_cnt increments on the same edge and wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction aborts to FETCH with no write strobes asserted on the reset edge.

Decomposition:
- riscv_ctrl_pkg holds:
  - State localparams.
  - Opcode constants: OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL.
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module, riscv_alu_decoder: combinational, inputs ALUOp[1:0], funct3, funct7b5, op[5]; outputs ALUControl and funct_illegal.
- The FSM and counter live in the top module.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1: states 0,1,7,8,0; RegWrite=1 only in ALUWB; retired_cnt=1 after 4 cycles.
- add x3,x1,x2 (0x002081B3) then sub (0x402081B3): ALUControl=000 in EXECR, then 001.
- sw x1,0(x0) (0x00102023) with mem_ready low for 3 cycles in MEMWRITE: MemWrite held 4 cycles; exactly one instr_retired pulse.
- beq with zero=1: PCWrite=1 in BRANCH; bne (SUPPORT_BNE=1) with zero=1: PCWrite=0.
- op=1111111, TRAP_ON_ILLEGAL=1: state_debug=11, illegal=1, no further enables until rst_n low; retired_cnt unchanged.
- CNT_W=4, 16 retired addi instructions: retired_cnt wraps to 0. Asserting rst_n low in MEMREAD: state=0 and all counters 0 asynchronously.
